// File: rtl/rd_pointer_empty.sv
// Read-side pointer/empty stage of the async FIFO: synchronizes the Gray write
// pointer into rclk and produces the read pointers, empty/almost-empty and occupancy.
module rd_pointer_empty #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned ALMOST_EMPTY_TH = 2
) (
  input  logic             rclk,
  input  logic             rd_srst,
  input  logic             rd_en,
  input  logic [WIDTH:0]   wr_ptr_gray,
  output logic [WIDTH-1:0] rd_addr,
  output logic [WIDTH:0]   rd_ptr,
  output logic [WIDTH:0]   rd_ptr_gray,
  output logic             empty,
  output logic             almost_empty,
  output logic [WIDTH:0]   rd_count,
  output logic             rd_valid,
  output logic             rd_underflow
);

  localparam int unsigned PW = WIDTH + 1;

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] gray_q, gray_d;
  logic [PW-1:0] wq_q [SYNC_STAGES];
  logic [PW-1:0] wq_d [SYNC_STAGES];
  logic [PW-1:0] count_q, count_d;
  logic          empty_q, empty_d;
  logic          almost_q, almost_d;
  logic          valid_q, valid_d;
  logic          underflow_q, underflow_d;
  logic [PW-1:0] wq_bin;
  logic          rd_fire;

  // Next-state: synchronizer shift, pointer advance, flags against synced write pointer
  always_comb begin
    rd_fire     = rd_en & ~empty_q;
    wq_d[0]     = wr_ptr_gray;
    for (int i = 1; i < int'(SYNC_STAGES); i++) begin
      wq_d[i] = wq_q[i-1];
    end
    rd_ptr_d    = rd_ptr_q + PW'(rd_fire);
    gray_d      = rd_ptr_d ^ (rd_ptr_d >> 1);
    wq_bin      = '0;
    wq_bin[PW-1] = wq_q[SYNC_STAGES-1][PW-1];
    for (int i = int'(PW) - 2; i >= 0; i--) begin
      wq_bin[i] = wq_bin[i+1] ^ wq_q[SYNC_STAGES-1][i];
    end
    count_d     = wq_bin - rd_ptr_d;
    empty_d     = (gray_d == wq_q[SYNC_STAGES-1]);
    almost_d    = (32'(count_d) <= ALMOST_EMPTY_TH);
    valid_d     = rd_fire;
    underflow_d = underflow_q | (rd_en & empty_q);
  end

  always_ff @(posedge rclk) begin
    if (rd_srst) begin
      rd_ptr_q    <= '0;
      gray_q      <= '0;
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        wq_q[i] <= '0;
      end
      count_q     <= '0;
      empty_q     <= 1'b1;
      almost_q    <= 1'b1;
      valid_q     <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      gray_q      <= gray_d;
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        wq_q[i] <= wq_d[i];
      end
      count_q     <= count_d;
      empty_q     <= empty_d;
      almost_q    <= almost_d;
      valid_q     <= valid_d;
      underflow_q <= underflow_d;
    end
  end

  assign rd_addr      = rd_ptr_q[WIDTH-1:0];
  assign rd_ptr       = rd_ptr_q;
  assign rd_ptr_gray  = gray_q;
  assign empty        = empty_q;
  assign almost_empty = almost_q;
  assign rd_count     = count_q;
  assign rd_valid     = valid_q;
  assign rd_underflow = underflow_q;

endmodule

// File: tb/tb_rd_pointer_empty.sv
// Directed bench for rd_pointer_empty with WIDTH=3, SYNC_STAGES=2, ALMOST_EMPTY_TH=2.
module tb_rd_pointer_empty;

  logic       rclk = 1'b0;
  logic       rd_srst;
  logic       rd_en;
  logic [3:0] wr_ptr_gray;
  logic [2:0] rd_addr;
  logic [3:0] rd_ptr;
  logic [3:0] rd_ptr_gray;
  logic       empty;
  logic       almost_empty;
  logic [3:0] rd_count;
  logic       rd_valid;
  logic       rd_underflow;

  int total = 0;
  int bad   = 0;

  rd_pointer_empty #(.WIDTH(3), .SYNC_STAGES(2), .ALMOST_EMPTY_TH(2)) dut (
    .rclk(rclk), .rd_srst(rd_srst), .rd_en(rd_en), .wr_ptr_gray(wr_ptr_gray),
    .rd_addr(rd_addr), .rd_ptr(rd_ptr), .rd_ptr_gray(rd_ptr_gray), .empty(empty),
    .almost_empty(almost_empty), .rd_count(rd_count), .rd_valid(rd_valid),
    .rd_underflow(rd_underflow)
  );

  always #5 rclk = ~rclk;

  // Advance one edge; sample and drive 1 time unit after it
  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reads(input int n);
    rd_en = 1'b1;
    repeat (n) tick();
    rd_en = 1'b0;
  endtask

  initial begin
    rd_srst = 1'b1; rd_en = 1'b1; wr_ptr_gray = 4'b0110;
    #2;
    // 1. reset with rd_en held high
    tick(); tick();
    chk("rst_ptr", 32'(rd_ptr), 0);
    chk("rst_gray", 32'(rd_ptr_gray), 0);
    chk("rst_addr", 32'(rd_addr), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_almost", 32'(almost_empty), 1);
    chk("rst_count", 32'(rd_count), 0);
    chk("rst_valid", 32'(rd_valid), 0);
    chk("rst_uflow", 32'(rd_underflow), 0);

    // 2. latency: change lands at the third edge
    rd_srst = 1'b0; rd_en = 1'b0; wr_ptr_gray = 4'b0000;
    tick();
    wr_ptr_gray = 4'b0001;
    tick(); chk("lat_e1_empty", 32'(empty), 1);
    tick(); chk("lat_e2_empty", 32'(empty), 1);
    tick();
    chk("lat_e3_empty", 32'(empty), 0);
    chk("lat_e3_count", 32'(rd_count), 1);
    chk("lat_e3_almost", 32'(almost_empty), 1);

    // 3. drain 5 entries then underflow (ptr=0 with 1 entry; write binary 5)
    wr_ptr_gray = 4'b0111;
    repeat (3) tick();
    chk("drain_count0", 32'(rd_count), 5);
    chk("drain_almost0", 32'(almost_empty), 0);
    rd_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("drain_addr", 32'(rd_addr), 32'(k));
      tick();
      chk("drain_valid", 32'(rd_valid), 1);
      chk("drain_ptr", 32'(rd_ptr), 32'(k + 1));
      chk("drain_count", 32'(rd_count), 32'(4 - k));
    end
    chk("drain_empty", 32'(empty), 1);
    chk("drain_uflow0", 32'(rd_underflow), 0);
    tick();
    rd_en = 1'b0;
    chk("uflow_set", 32'(rd_underflow), 1);
    chk("uflow_ptr", 32'(rd_ptr), 5);
    chk("uflow_valid", 32'(rd_valid), 0);
    tick();
    chk("uflow_sticky", 32'(rd_underflow), 1);

    // 4. wrap: write to binary 13, drain, then binary 3 (wrapped)
    wr_ptr_gray = 4'b1011;
    repeat (3) tick();
    chk("wrap_count8", 32'(rd_count), 8);
    reads(8);
    chk("wrap_ptr13", 32'(rd_ptr), 13);
    chk("wrap_empty13", 32'(empty), 1);
    wr_ptr_gray = 4'b0010;
    repeat (3) tick();
    chk("wrap_count6", 32'(rd_count), 6);
    reads(2);
    chk("wrap_ptr15", 32'(rd_ptr), 15);
    chk("wrap_gray15", 32'(rd_ptr_gray), 32'b1000);
    reads(1);
    chk("wrap_ptr0", 32'(rd_ptr), 0);
    chk("wrap_gray0", 32'(rd_ptr_gray), 0);
    chk("wrap_count3", 32'(rd_count), 3);
    chk("wrap_empty0", 32'(empty), 0);

    // 5. full occupancy: write binary 8 with rd_ptr=0
    wr_ptr_gray = 4'b1100;
    repeat (3) tick();
    chk("full_count", 32'(rd_count), 8);
    chk("full_empty", 32'(empty), 0);
    chk("full_almost", 32'(almost_empty), 0);
    reads(5);
    chk("full_cnt3", 32'(rd_count), 3);
    chk("full_alm3", 32'(almost_empty), 0);
    reads(1);
    chk("full_cnt2", 32'(rd_count), 2);
    chk("full_alm2", 32'(almost_empty), 1);
    reads(2);
    chk("full_drained", 32'(empty), 1);
    chk("full_ptr", 32'(rd_ptr), 8);

    // 6. mid-operation reset: rd_ptr=3, write binary 7
    rd_srst = 1'b1;
    tick();
    rd_srst = 1'b0; wr_ptr_gray = 4'b0100;
    repeat (3) tick();
    chk("mid_count7", 32'(rd_count), 7);
    reads(3);
    chk("mid_ptr3", 32'(rd_ptr), 3);
    chk("mid_count4", 32'(rd_count), 4);
    rd_srst = 1'b1; rd_en = 1'b1;
    tick();
    rd_srst = 1'b0; rd_en = 1'b0;
    chk("mid_rst_ptr", 32'(rd_ptr), 0);
    chk("mid_rst_valid", 32'(rd_valid), 0);
    chk("mid_rst_empty", 32'(empty), 1);
    chk("mid_rst_count", 32'(rd_count), 0);
    tick(); chk("mid_e1_empty", 32'(empty), 1);
    tick(); chk("mid_e2_empty", 32'(empty), 1);
    tick();
    chk("mid_e3_count", 32'(rd_count), 7);
    chk("mid_e3_empty", 32'(empty), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
